// File: rtl/cpu_2a03_oam_dma_if.sv
// CPU-side and system-bus-side signals of the OAM DMA engine.
// master = the DMA engine itself; slave = the CPU core plus system bus around it.
interface cpu_2a03_oam_dma_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw;
    logic              cpu_rdy;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
        output cpu_rdy, bus_addr, bus_wdata, bus_rw
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
        input  cpu_rdy, bus_addr, bus_wdata, bus_rw
    );
endinterface

// File: rtl/cpu_2a03_oam_dma.sv
// Sprite/OAM DMA engine beside the 2A03 core: halts the CPU and copies a page to DEST_ADDR.
// Optional completion interrupt with status-read clear is enabled by defining DMA_DONE_IRQ_EN.
module cpu_2a03_oam_dma #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       XFER_LEN  = 256,
    parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
    parameter logic [ADDR_W-1:0] DEST_ADDR = 16'h2004,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 16'h4015
) (
    input  logic                      clock,
    input  logic                      nreset,
    cpu_2a03_oam_dma_if.master        io,
    output logic                      dma_active,
    output logic                      done_irq
);
    localparam int unsigned PAGE_W = ADDR_W - 8;
    localparam int unsigned IDX_W  = $clog2(XFER_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RD, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic                par;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [PAGE_W-1:0]   page;
    logic [DATA_W-1:0]   buf_q;
    logic                load_page, capture, last_wr;
    logic                trig;
    logic [ADDR_W-1:0]   rd_addr;

    assign trig    = !io.cpu_rw && (io.cpu_addr == TRIG_ADDR);
    assign rd_addr = {page, 8'h00} + ADDR_W'(idx);

    always_ff @(posedge clock) begin
        if (nreset) begin
            state <= S_IDLE;
            par   <= 1'b0;
            idx   <= '0;
            page  <= '0;
            buf_q <= '0;
        end else begin
            state <= state_nxt;
            par   <= ~par;
            idx   <= idx_nxt;
            if (load_page) page  <= PAGE_W'(io.cpu_wdata);
            if (capture)   buf_q <= io.bus_rdata;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        load_page    = 1'b0;
        capture      = 1'b0;
        last_wr      = 1'b0;
        io.cpu_rdy   = 1'b1;
        dma_active   = 1'b0;
        io.bus_addr  = io.cpu_addr;
        io.bus_wdata = io.cpu_wdata;
        io.bus_rw    = io.cpu_rw;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (trig) begin
                    state_nxt = S_WAIT_RD;
                    load_page = 1'b1;
                    idx_nxt   = '0;
                end
            end
            S_WAIT_RD: begin
                // RDY only stalls read cycles, so pending CPU writes drain first
                io.cpu_rdy = 1'b0;
                if (io.cpu_rw) state_nxt = S_HALT;
            end
            S_HALT: begin
                io.cpu_rdy = 1'b0;
                dma_active = 1'b1;
                io.bus_rw  = 1'b1;
                // par toggles each edge: next cycle is a put cycle when par is 0 now
                state_nxt  = par ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                io.cpu_rdy = 1'b0;
                dma_active = 1'b1;
                io.bus_rw  = 1'b1;
                state_nxt  = S_READ;
            end
            S_READ: begin
                io.cpu_rdy  = 1'b0;
                dma_active  = 1'b1;
                io.bus_addr = rd_addr;
                io.bus_rw   = 1'b1;
                capture     = 1'b1;
                state_nxt   = S_WRITE;
            end
            S_WRITE: begin
                io.cpu_rdy   = 1'b0;
                dma_active   = 1'b1;
                io.bus_addr  = DEST_ADDR;
                io.bus_wdata = buf_q;
                io.bus_rw    = 1'b0;
                idx_nxt      = idx + 1'b1;
                if (idx == IDX_W'(XFER_LEN - 1)) begin
                    state_nxt = S_DONE;
                    last_wr   = 1'b1;
                end else begin
                    state_nxt = S_READ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef DMA_DONE_IRQ_EN
    logic irq_q;
    logic stat_rd;

    assign stat_rd = io.cpu_rdy && io.cpu_rw && (io.cpu_addr == STAT_ADDR);

    always_ff @(posedge clock) begin
        if (nreset)       irq_q <= 1'b0;
        else if (last_wr) irq_q <= 1'b1;
        else if (stat_rd) irq_q <= 1'b0;
    end

    assign done_irq = irq_q;
`else
    logic unused_stat;
    assign unused_stat = ^{STAT_ADDR, last_wr};
    assign done_irq    = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_2a03_oam_dma.sv
// Directed bench for cpu_2a03_oam_dma: pass-through, both parity alignments, write drain,
// mid-transfer reset and (with DMA_DONE_IRQ_EN) the completion interrupt.
module tb_cpu_2a03_oam_dma;
    logic        clock = 1'b0;
    logic        nreset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic        dma_active;
    logic        done_irq;
    logic        par_tb = 1'b0;
    logic        exp_irq;
    int          n_vec = 0;
    int          n_err = 0;

    cpu_2a03_oam_dma_if #(.ADDR_W(16), .DATA_W(8)) io ();

    cpu_2a03_oam_dma #(
        .ADDR_W(16), .DATA_W(8), .XFER_LEN(256),
        .TRIG_ADDR(16'h4014), .DEST_ADDR(16'h2004), .STAT_ADDR(16'h4015)
    ) dut (
        .clock(clock), .nreset(nreset), .io(io),
        .dma_active(dma_active), .done_irq(done_irq)
    );

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    assign io.cpu_addr  = cpu_addr;
    assign io.cpu_wdata = cpu_wdata;
    assign io.cpu_rw    = cpu_rw;
    assign io.bus_rdata = mem_f(io.bus_addr);

    always #5 clock = ~clock;

    // independent model of the get/put parity
    always @(posedge clock) par_tb <= nreset ? 1'b0 : ~par_tb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_addr = a; cpu_wdata = d; cpu_rw = rw;
        @(negedge clock);
        chk("pt_addr", io.bus_addr, a);
        chk("pt_wdata", io.bus_wdata, d);
        chk("pt_rw", io.bus_rw, rw);
        chk("pt_rdy", io.cpu_rdy, 1);
        chk("pt_active", dma_active, 0);
        chk("pt_irq", done_irq, exp_irq);
        tick();
`ifdef DMA_DONE_IRQ_EN
        if (rw && a == 16'h4015) exp_irq = 1'b0;
`endif
    endtask

    task automatic dma_cycle(input string tag, input logic [15:0] a, input logic [7:0] d,
                             input logic rw, input logic act);
        @(negedge clock);
        chk({tag, "_addr"}, io.bus_addr, a);
        if (!rw) chk({tag, "_wdata"}, io.bus_wdata, d);
        chk({tag, "_rw"}, io.bus_rw, rw);
        chk({tag, "_rdy"}, io.cpu_rdy, 0);
        chk({tag, "_active"}, dma_active, act);
        chk({tag, "_irq"}, done_irq, exp_irq);
    endtask

    // trigger page pg, drain n_wr CPU writes, then run the copy; abort_at>=0 resets at that READ
    task automatic do_xfer(input logic [7:0] pg, input int n_wr, input logic rd_par, input int abort_at);
        logic        align;
        int          halted;
        logic [15:0] ra;
        if ((par_tb ^ (n_wr % 2 == 0)) != rd_par) idle_cycle(16'h0000, 8'h00, 1'b1);
        idle_cycle(16'h4014, pg, 1'b0);
        for (int i = 0; i < n_wr; i++) begin
            cpu_addr  = (i == 1) ? 16'h4014 : 16'h01FD;
            cpu_wdata = (i == 1) ? 8'h77 : 8'hA0;
            cpu_rw    = 1'b0;
            dma_cycle("wait_wr", cpu_addr, cpu_wdata, 1'b0, 1'b0);
            tick();
        end
        cpu_addr = 16'hC123; cpu_wdata = 8'h00; cpu_rw = 1'b1;
        dma_cycle("wait_rd", 16'hC123, 8'h00, 1'b1, 1'b0);
        tick();
        halted = 1;
        dma_cycle("halt", 16'hC123, 8'h00, 1'b1, 1'b1);
        tick();
        align = rd_par;
        if (align) begin
            halted++;
            dma_cycle("align", 16'hC123, 8'h00, 1'b1, 1'b1);
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            ra = {pg, 8'(i)};
            halted++;
            dma_cycle("read", ra, 8'h00, 1'b1, 1'b1);
            if (i == abort_at) begin
                nreset = 1'b1;
                tick();
                nreset  = 1'b0;
                exp_irq = 1'b0;
                @(negedge clock);
                chk("abort_rdy", io.cpu_rdy, 1);
                chk("abort_active", dma_active, 0);
                chk("abort_rw", io.bus_rw, 1);
                chk("abort_addr", io.bus_addr, 16'hC123);
                chk("abort_irq", done_irq, 0);
                tick();
                return;
            end
            tick();
            halted++;
            dma_cycle("write", 16'h2004, mem_f(ra), 1'b0, 1'b1);
            tick();
        end
`ifdef DMA_DONE_IRQ_EN
        exp_irq = 1'b1;
`endif
        chk("halted_cycles", halted, align ? 514 : 513);
        @(negedge clock);
        chk("done_rdy", io.cpu_rdy, 1);
        chk("done_active", dma_active, 0);
        chk("done_addr", io.bus_addr, 16'hC123);
        chk("done_irq", done_irq, exp_irq);
        tick();
    endtask

    initial begin
        nreset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rw = 1'b1; exp_irq = 1'b0;
        tick();
        tick();
        nreset = 1'b0;
        idle_cycle(16'h8000, 8'h00, 1'b1);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] a;
            logic        rw;
            a  = 16'($urandom);
            rw = 1'($urandom);
            if (!rw && a == 16'h4014) a = 16'h4013;
            idle_cycle(a, 8'($urandom), rw);
        end

        do_xfer(8'h02, 0, 1'b0, -1);
        idle_cycle(16'hC124, 8'h00, 1'b1);
        do_xfer(8'h03, 0, 1'b1, -1);
        idle_cycle(16'h0300, 8'h11, 1'b0);
        do_xfer(8'h04, 2, 1'b0, -1);
        idle_cycle(16'hC124, 8'h00, 1'b1);
        do_xfer(8'h05, 0, 1'b0, 100);
        idle_cycle(16'h2002, 8'h00, 1'b1);
        do_xfer(8'hFF, 0, 1'b1, -1);
        idle_cycle(16'h1234, 8'h00, 1'b1);
        idle_cycle(16'h4015, 8'h00, 1'b1);
        idle_cycle(16'h1235, 8'h00, 1'b1);
        idle_cycle(16'h4015, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
